// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, multiply-sequencer states and widths.
package alu_pkg;

    localparam int BUS_W     = 32;
    localparam int MUL_CNT_W = $clog2(BUS_W) + 1;

    localparam logic [3:0] ALUFUN_ADD = 4'b0100;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer_operand_regs.sv
// Accumulator, multiplicand and multiplier registers for the shift-add multiply loop.
module mul_operand_regs #(
    parameter int bus = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [bus-1:0] load_acc,
    input  logic [bus-1:0] load_mcand,
    input  logic [bus-1:0] load_mplier,
    input  logic           shift,
    input  logic           acc_we,
    input  logic [bus-1:0] acc_in,
    output logic [bus-1:0] acc,
    output logic [bus-1:0] mcand,
    output logic [bus-1:0] mplier
);

    logic [bus-1:0] acc_q,    acc_d;
    logic [bus-1:0] mcand_q,  mcand_d;
    logic [bus-1:0] mplier_q, mplier_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load) begin
            acc_d    = load_acc;
            mcand_d  = load_mcand;
            mplier_d = load_mplier;
        end else begin
            if (acc_we) acc_d = acc_in;
            if (shift) begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign acc    = acc_q;
    assign mcand  = mcand_q;
    assign mplier = mplier_q;

endmodule

// File: rtl/alu_mul_sequencer.sv
// ARMv4 MUL/MLA sequencer that borrows the shared ALU adder for a shift-add loop.
// Define MUL_EARLY_TERM_EN to leave the loop once the remaining multiplier is zero.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int         bus     = BUS_W,
    parameter logic [3:0] ADD_FUN = ALUFUN_ADD
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           accumulate,
    input  logic [bus-1:0] rm,
    input  logic [bus-1:0] rs,
    input  logic [bus-1:0] rn,
    output logic           ready,
    output logic           stall,
    output logic           alu_sel,
    output logic [3:0]     alu_fun,
    output logic [bus-1:0] alu_a,
    output logic [bus-1:0] alu_b,
    input  logic [bus-1:0] alu_y,
    output logic           done,
    output logic [bus-1:0] result,
    output logic           n_flag,
    output logic           z_flag
);

    localparam logic [MUL_CNT_W-1:0] LAST_ITER = MUL_CNT_W'(bus - 1);

    mul_state_t           state_q, state_d;
    logic [MUL_CNT_W-1:0] cnt_q,   cnt_d;
    logic [bus-1:0]       result_q, result_d;
    logic                 n_q, n_d;
    logic                 z_q, z_d;

    logic           load, shift, acc_we, last_iter;
    logic [bus-1:0] acc, mcand, mplier;

    mul_operand_regs #(.bus(bus)) u_operand_regs (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_acc    (accumulate ? rn : '0),
        .load_mcand  (rm),
        .load_mplier (rs),
        .shift       (shift),
        .acc_we      (acc_we),
        .acc_in      (alu_y),
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        n_d       = n_q;
        z_d       = z_q;
        load      = 1'b0;
        shift     = 1'b0;
        acc_we    = 1'b0;
        last_iter = 1'b0;
        alu_sel   = 1'b0;
        alu_fun   = '0;
        alu_a     = '0;
        alu_b     = '0;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load  = 1'b1;
                    cnt_d = '0;
`ifdef MUL_EARLY_TERM_EN
                    state_d = (rs == '0) ? DONE : ITER;
`else
                    state_d = ITER;
`endif
                end
            end
            ITER: begin
                alu_sel   = 1'b1;
                alu_fun   = ADD_FUN;
                alu_a     = acc;
                alu_b     = mcand;
                shift     = 1'b1;
                acc_we    = mplier[0];
                cnt_d     = cnt_q + 1'b1;
                last_iter = (cnt_q == LAST_ITER);
`ifdef MUL_EARLY_TERM_EN
                last_iter = last_iter || ((mplier >> 1) == '0);
`endif
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                done     = 1'b1;
                result_d = acc;
                n_d      = acc[bus-1];
                z_d      = (acc == '0);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end

    // Result is presented live in DONE and held afterwards for the pipeline.
    assign result = result_d;
    assign n_flag = n_d;
    assign z_flag = z_d;
    assign ready  = (state_q == IDLE);
    assign stall  = (state_q == ITER) || ((state_q == IDLE) && start);

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: transaction-level model plus directed cases.
module tb_alu_mul_sequencer;

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        accumulate = 1'b0;
    logic [31:0] rm = '0, rs = '0, rn = '0;
    logic        ready, stall, alu_sel, done, n_flag, z_flag;
    logic [3:0]  alu_fun;
    logic [31:0] alu_a, alu_b, alu_y, result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Stand-in ALU: only the ADD code adds, so a wrong function code corrupts the product.
    assign alu_y = (alu_fun == 4'b0100) ? (alu_a + alu_b) : (alu_a ^ alu_b);

    alu_mul_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .accumulate (accumulate),
        .rm         (rm),
        .rs         (rs),
        .rn         (rn),
        .ready      (ready),
        .stall      (stall),
        .alu_sel    (alu_sel),
        .alu_fun    (alu_fun),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .done       (done),
        .result     (result),
        .n_flag     (n_flag),
        .z_flag     (z_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int calc_k(input logic [31:0] v);
        int k = 0;
        for (int i = 0; i < 32; i++) if (v[i]) k = i + 1;
        return EARLY ? k : 32;
    endfunction

    // Transaction model: phase 0 = idle, 1..k = iterating, k+1 = done cycle.
    int          m_phase = 0;
    int          m_k = 0;
    logic [31:0] m_rm = '0, m_rs = '0, m_init = '0, m_exp = '0;
    logic [31:0] m_last_res = '0;
    logic        m_last_n = 1'b0, m_last_z = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase    = 0;
            m_last_res = '0;
            m_last_n   = 1'b0;
            m_last_z   = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_rm    = rm;
                m_rs    = rs;
                m_init  = accumulate ? rn : 32'd0;
                m_exp   = m_init + m_rm * m_rs;
                m_k     = calc_k(rs);
                m_phase = 1;
            end
        end else if (m_phase == m_k + 1) begin
            m_phase    = 0;
            m_last_res = m_exp;
            m_last_n   = m_exp[31];
            m_last_z   = (m_exp == 0);
        end else begin
            m_phase++;
        end
    end

    always @(negedge clk) begin
        logic [31:0] mask, exp_a, exp_b;
        if (reset) begin
            check("rst_ready", ready, 1);
            check("rst_stall", stall, 0);
            check("rst_done", done, 0);
            check("rst_result", result, 0);
            check("rst_n", n_flag, 0);
            check("rst_z", z_flag, 0);
            check("rst_alu_sel", alu_sel, 0);
        end else if (m_phase == 0) begin
            check("idle_ready", ready, 1);
            check("idle_stall", stall, start);
            check("idle_done", done, 0);
            check("idle_alu_sel", alu_sel, 0);
            check("idle_alu_fun", alu_fun, 0);
            check("idle_alu_a", alu_a, 0);
            check("idle_alu_b", alu_b, 0);
            check("hold_result", result, m_last_res);
            check("hold_n", n_flag, m_last_n);
            check("hold_z", z_flag, m_last_z);
        end else if (m_phase <= m_k) begin
            mask  = (32'd1 << (m_phase - 1)) - 32'd1;
            exp_a = m_init + m_rm * (m_rs & mask);
            exp_b = m_rm << (m_phase - 1);
            check("iter_ready", ready, 0);
            check("iter_stall", stall, 1);
            check("iter_done", done, 0);
            check("iter_alu_sel", alu_sel, 1);
            check("iter_alu_fun", alu_fun, 4'b0100);
            check("iter_alu_a", alu_a, exp_a);
            check("iter_alu_b", alu_b, exp_b);
        end else begin
            check("done_ready", ready, 0);
            check("done_stall", stall, 0);
            check("done_pulse", done, 1);
            check("done_alu_sel", alu_sel, 0);
            check("done_result", result, m_exp);
            check("done_n", n_flag, m_exp[31]);
            check("done_z", z_flag, (m_exp == 0));
        end
    end

    // Issue one op and pin its latency, ALU usage and result against hand-computed values.
    task automatic run_op(input string nm, input logic [31:0] a_rm, input logic [31:0] a_rs,
                          input logic [31:0] a_rn, input logic a_acc, input logic ext_pulse,
                          input int exp_cyc, input logic [31:0] exp_res,
                          input logic exp_n, input logic exp_z);
        int cyc = 1;
        int sel_cnt = 0;
        bit seen = 0;
        @(posedge clk); #1;
        start = 1'b1; rm = a_rm; rs = a_rs; rn = a_rn; accumulate = a_acc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (ext_pulse && cyc == 1) begin
                start = 1'b1; rm = 32'h0000_1234; rs = 32'h5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (alu_sel) sel_cnt++;
            if (done) seen = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check({nm, "_done_seen"}, seen, 1);
        check({nm, "_done_cycle"}, cyc, exp_cyc);
        check({nm, "_alu_sel_cycles"}, sel_cnt, exp_cyc - 1);
        check({nm, "_result"}, result, exp_res);
        check({nm, "_n"}, n_flag, exp_n);
        check({nm, "_z"}, z_flag, exp_z);
    endtask

    initial begin
        bit seen_done;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_op("mul_7x6", 32'd7, 32'd6, 32'd0, 1'b0, 1'b0,
               EARLY ? 4 : 33, 32'd42, 1'b0, 1'b0);
        run_op("mla_carry", 32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b0,
               EARLY ? 3 : 33, 32'd3, 1'b0, 1'b0);
        run_op("mul_rs0", 32'd123, 32'd0, 32'd0, 1'b0, 1'b0,
               EARLY ? 1 : 33, 32'd0, 1'b0, 1'b1);
        run_op("mla_rs0", 32'd123, 32'd0, 32'd9, 1'b1, 1'b0,
               EARLY ? 1 : 33, 32'd9, 1'b0, 1'b0);
        run_op("mul_neg", 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1,
               EARLY ? 2 : 33, 32'h8000_0000, 1'b1, 1'b0);
        run_op("mul_3x1", 32'd3, 32'd1, 32'd0, 1'b0, 1'b0,
               EARLY ? 2 : 33, 32'd3, 1'b0, 1'b0);

        // Reset while idle clears the held result and flags.
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("idle_reset_result", result, 0);
        check("idle_reset_z", z_flag, 0);
        check("idle_reset_ready", ready, 1);
        @(posedge clk); #1 reset = 1'b0;

        // Leave a nonzero result held, then abort a long multiply mid-loop.
        run_op("mul_5x5", 32'd5, 32'd5, 32'd0, 1'b0, 1'b0,
               EARLY ? 4 : 33, 32'd25, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; rm = 32'd3; rs = 32'hFFFF_FFFF; accumulate = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_ready", ready, 1);
        check("abort_result", result, 0);

        // Random traffic, including start pulses while busy and short multipliers.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start      = ($urandom_range(0, 2) == 0);
            rm         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rs         = $urandom >> $urandom_range(0, 32);
            rn         = $urandom;
            accumulate = $urandom_range(0, 1) == 1;
        end
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
